multicycle_controller: RTL and testbench

Sequencing controller for the multicycle RV32I core, in which one ALU, one unified instruction/data memory port and the register file are shared across several cycles of each instruction. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. Each step drives the datapath mux selects and write enables. Memory-facing states stall on a ready handshake. The ALU control code is derived combinationally from funct3/funct7b5 with the same encoding the single-cycle core uses.

---
 rtl/multicycle_controller.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing controller for the multicycle RV32I core.
// A Moore FSM steps each instruction through fetch/decode/execute/memory/
// writeback and drives the shared-datapath selects and write enables.
//
// Memory handshake: the controller holds its address/strobe outputs steady
// in FETCH, MEMREAD and MEMWRITE; mem_ready=1 in one of those states means the
// memory finished the access this cycle, and the FSM leaves on that edge.
// mem_ready is ignored in every other state.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUOp: 00 add, 01 sub, 10 decode from funct fields
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;

  // State register; reset returns to FETCH without waiting for a clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Next-state and per-state datapath controls (Moore, plus mem_ready gating)
  always_comb begin
    state_d   = S_FETCH;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    RegWrite  = 1'b0;
    illegal   = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed while the instruction is read
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        alu_op    = ALUOP_ADD;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // OldPC + imm: branch/jump target is ready before execute
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_ADD;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_ADD;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        state_d   = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe stays high until the memory accepts the write
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        MemWrite  = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        alu_op  = ALUOP_FUNC;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNC;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // Jump target from DECODE goes to PC; ALU forms OldPC+4 for rd
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        alu_op    = ALUOP_ADD;
        ResultSrc = 2'b00;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        // rs1 - rs2 sets zero in this same cycle; target sits in ALUOut
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_SUB;
        ResultSrc = 2'b00;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        // Unreachable encodings recover to FETCH with every enable low
        state_d = S_FETCH;
      end
    endcase
  end

  assign PCWrite = pc_update | (branch & zero);

  // Immediate format depends only on the opcode
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder, same encoding as the single-cycle core
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNC: begin
        case (funct3)
          // sub only for R-type (op[5]=1); addi never subtracts
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a table of per-cycle
// {inputs, expected outputs} records walked instruction by instruction,
// plus hand-written asynchronous reset sequences.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] SYS = 7'b1110011;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       RegWrite;
  logic       illegal;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .illegal(illegal),
    .state(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Snapshot order: state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
  // ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal
  localparam int SW_W = 21;
  logic [SW_W-1:0] act;
  assign act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal};

  typedef struct {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            f7;
    logic            z;
    logic            mr;
    logic [SW_W-1:0] exp;
  } vec_t;

  vec_t            vecs[$];
  logic [SW_W-1:0] exp_q[$];
  int              total = 0;
  int              bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // One table row: inputs for the cycle and the outputs expected mid-cycle
  task automatic v(input logic [6:0] o, input logic [2:0] f3, input int f7,
                   input int z, input int mr, input int st, input int pcw,
                   input int adr, input int mw, input int irw, input int rs,
                   input int sa, input int sb, input int imm, input int alc,
                   input int rw, input int ill);
    vec_t r;
    r.op  = o;
    r.f3  = f3;
    r.f7  = 1'(f7);
    r.z   = 1'(z);
    r.mr  = 1'(mr);
    r.exp = {4'(st), 1'(pcw), 1'(adr), 1'(mw), 1'(irw), 2'(rs), 2'(sa),
             2'(sb), 2'(imm), 3'(alc), 1'(rw), 1'(ill)};
    vecs.push_back(r);
  endtask

  // R/I-type: FETCH, DECODE, EXECUTE(R or I), ALUWB
  task automatic add_alu(input logic [6:0] o, input logic [2:0] f3, input int f7,
                         input int alc, input int exec_st, input int sb);
    v(o, f3, f7, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
    v(o, f3, f7, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0);
    v(o, f3, f7, 0, 0, exec_st, 0, 0, 0, 0, 2'b00, 2'b10, sb, 2'b00, alc, 0, 0);
    v(o, f3, f7, 1, 0, 7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
  endtask

  // Driver: apply one row, push its expectation, compare mid-cycle
  task automatic apply_vec(input int idx);
    logic [SW_W-1:0] e;
    op        = vecs[idx].op;
    funct3    = vecs[idx].f3;
    funct7b5  = vecs[idx].f7;
    zero      = vecs[idx].z;
    mem_ready = vecs[idx].mr;
    exp_q.push_back(vecs[idx].exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("vec%0d", idx), 32'(act), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;

    // ---- table ----
    // lw, mem_ready high throughout: 0,1,2,3,4
    v(LW, 3'b010, 0, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 1, 2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 1, 3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 1, 4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    // lw with FETCH and MEMREAD stalls, mem_ready low where it is ignored
    v(LW, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 0, 2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 0, 3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 1, 3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    v(LW, 3'b010, 0, 0, 0, 4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    // sw with two stall cycles in MEMWRITE
    v(SW, 3'b010, 0, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
    v(SW, 3'b010, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0, 0);
    v(SW, 3'b010, 0, 0, 1, 2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0);
    v(SW, 3'b010, 0, 0, 0, 5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0);
    v(SW, 3'b010, 0, 0, 0, 5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0);
    v(SW, 3'b010, 0, 0, 1, 5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0);
    // R-type: sub, add, slt, or, and, sll(other), xor with funct7b5 set
    add_alu(RT, 3'b000, 1, 3'b001, 6, 2'b00);
    add_alu(RT, 3'b000, 0, 3'b000, 6, 2'b00);
    add_alu(RT, 3'b010, 0, 3'b101, 6, 2'b00);
    add_alu(RT, 3'b110, 0, 3'b011, 6, 2'b00);
    add_alu(RT, 3'b111, 0, 3'b010, 6, 2'b00);
    add_alu(RT, 3'b001, 0, 3'b000, 6, 2'b00);
    add_alu(RT, 3'b100, 1, 3'b000, 6, 2'b00);
    // I-type: addi with bit30 set must still add
    add_alu(IT, 3'b000, 1, 3'b000, 8, 2'b01);
    add_alu(IT, 3'b010, 0, 3'b101, 8, 2'b01);
    add_alu(IT, 3'b110, 1, 3'b011, 8, 2'b01);
    add_alu(IT, 3'b111, 0, 3'b010, 8, 2'b01);
    add_alu(IT, 3'b101, 1, 3'b000, 8, 2'b01);
    // jal
    v(JL, 3'b000, 0, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0, 0);
    v(JL, 3'b000, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 0, 0);
    v(JL, 3'b000, 0, 0, 0, 9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0);
    v(JL, 3'b000, 0, 0, 0, 7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 0);
    // beq taken (zero high in DECODE must not write PC)
    v(BQ, 3'b000, 0, 1, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 0);
    v(BQ, 3'b000, 0, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0, 0);
    v(BQ, 3'b000, 0, 1, 0, 10, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0);
    // beq not taken, funct fields must not affect the subtract
    v(BQ, 3'b110, 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 0);
    v(BQ, 3'b110, 1, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 0);
    v(BQ, 3'b110, 1, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0, 0);
    v(BQ, 3'b110, 1, 0, 1, 10, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0);
    // illegal opcodes: two cycles, pulse in DECODE
    v(SYS, 3'b000, 0, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
    v(SYS, 3'b000, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 1);
    v(7'b0000000, 3'b000, 0, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
    v(7'b0000000, 3'b000, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 1);
    v(LW, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);

    // ---- reset state (asserted from time 0) ----
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_enables", 32'({IRWrite, PCWrite, MemWrite, RegWrite, illegal}), 32'd0);
    check("rst_sel", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}), 32'b0_00_10_10_000);
    mem_ready = 1'b1;
    #1;
    check("rst_follow_ready", 32'({IRWrite, PCWrite}), 32'b11);
    step();
    check("rst_hold", 32'(state), 32'd0);
    reset = 1'b0;

    // ---- table walk ----
    for (int i = 0; i < vecs.size(); i++) apply_vec(i);

    // ---- async reset mid-EXECUTER ----
    op = RT; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0; mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    #1;
    check("pre_rst_exec", 32'(state), 32'd6);
    reset = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_en", 32'({IRWrite, PCWrite, MemWrite, RegWrite}), 32'd0);
    check("async_rst_sel", 32'({ALUSrcB, ResultSrc, ALUControl}), 32'b10_10_000);
    step();
    check("rst_held_state", 32'(state), 32'd0);
    check("rst_held_en", 32'({IRWrite, PCWrite, MemWrite, RegWrite}), 32'd0);
    mem_ready = 1'b1;
    reset = 1'b0;
    step();
    check("first_edge_adv", 32'(state), 32'd1);

    // ---- async reset during a stalled MEMWRITE ----
    op = SW;
    step();
    step();
    mem_ready = 1'b0;
    #1;
    check("memwrite_on", 32'({state, MemWrite}), 32'({4'd5, 1'b1}));
    reset = 1'b1;
    #1;
    check("memwrite_drop", 32'({state, MemWrite, RegWrite}), 32'd0);
    step();
    reset = 1'b0;
    check("after_rst_fetch", 32'(state), 32'd0);

    if (exp_q.size() != 0) check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
